// File: rtl/j_brl_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : j_brl_stage
// Description : Two-stage pipelined control wrapper around the Jerry barrel
//               shifter (decode/issue stage, capture/writeback stage).
//               Optional macro BRL_FLAGS_EN enables the Z/N/C flag registers.
// Revision    : 1.0 - initial release
// ============================================================================
module j_brl_stage (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_cnt,
    input  logic [31:0] in_srca,
    input  logic [31:0] in_dstd,
    input  logic [4:0]  in_dreg,
    output logic        brlmux_0,
    output logic        brlmux_1,
    output logic [31:0] srcdp,
    output logic [31:0] brld,
    input  logic [31:0] brlq,
    input  logic        brl_carry,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dreg,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c
);

    localparam logic [2:0] c_OP_SH    = 3'd0;
    localparam logic [2:0] c_OP_SHA   = 3'd1;
    localparam logic [2:0] c_OP_ROR   = 3'd2;
    localparam logic [2:0] c_OP_SHLQ  = 3'd3;
    localparam logic [2:0] c_OP_SHRQ  = 3'd4;
    localparam logic [2:0] c_OP_SHARQ = 3'd5;
    localparam logic [2:0] c_OP_RORQ  = 3'd6;

    localparam logic [1:0] c_MODE_LOG = 2'b00;
    localparam logic [1:0] c_MODE_ROT = 2'b10;
    localparam logic [1:0] c_MODE_ARI = 2'b11;

    logic        r_s1_valid;
    logic [1:0]  r_mode;
    logic [31:0] r_srcdp;
    logic [31:0] r_brld;
    logic [4:0]  r_s1_dreg;

    logic        r_s2_valid;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_dreg;

    logic        w_s2_adv;
    logic        w_accept;
    logic        w_wb_fire;
    logic [31:0] w_qcnt;
    logic [1:0]  w_mode;
    logic [31:0] w_srcdp;

    assign w_s2_adv  = r_s1_valid & (~r_s2_valid | wb_ready);
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_accept  = in_valid & in_ready;
    assign w_wb_fire = r_s2_valid & wb_ready;

    // Quick immediate of 0 stands for a count of 32
    assign w_qcnt = (in_cnt == 5'd0) ? 32'd32 : {27'd0, in_cnt};

    always_comb begin
        w_mode  = c_MODE_LOG;
        w_srcdp = 32'd0;
        case (in_op)
            c_OP_SH:    begin w_mode = c_MODE_LOG; w_srcdp = in_srca;  end
            c_OP_SHA:   begin w_mode = c_MODE_ARI; w_srcdp = in_srca;  end
            c_OP_ROR:   begin w_mode = c_MODE_ROT; w_srcdp = in_srca;  end
            c_OP_SHLQ:  begin w_mode = c_MODE_LOG; w_srcdp = -w_qcnt;  end
            c_OP_SHRQ:  begin w_mode = c_MODE_LOG; w_srcdp = w_qcnt;   end
            c_OP_SHARQ: begin w_mode = c_MODE_ARI; w_srcdp = w_qcnt;   end
            c_OP_RORQ:  begin w_mode = c_MODE_ROT; w_srcdp = w_qcnt;   end
            default:    begin w_mode = c_MODE_LOG; w_srcdp = 32'd0;    end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_mode     <= 2'b00;
            r_srcdp    <= 32'd0;
            r_brld     <= 32'd0;
            r_s1_dreg  <= 5'd0;
            r_s2_valid <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_dreg  <= 5'd0;
        end else begin
            // Stage 1 keeps its contents while stalled so the shifter inputs stay stable
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_mode     <= w_mode;
                r_srcdp    <= w_srcdp;
                r_brld     <= in_dstd;
                r_s1_dreg  <= in_dreg;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_wb_data  <= brlq;
                r_wb_dreg  <= r_s1_dreg;
            end else if (w_wb_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

`ifdef BRL_FLAGS_EN
    logic r_s2_z;
    logic r_s2_n;
    logic r_s2_c;
    logic r_flag_z;
    logic r_flag_n;
    logic r_flag_c;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_s2_z   <= 1'b0;
            r_s2_n   <= 1'b0;
            r_s2_c   <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_z <= (brlq == 32'd0);
                r_s2_n <= brlq[31];
                r_s2_c <= brl_carry;
            end
            // Architectural flags commit only when the result is consumed
            if (w_wb_fire) begin
                r_flag_z <= r_s2_z;
                r_flag_n <= r_s2_n;
                r_flag_c <= r_s2_c;
            end
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_c = r_flag_c;
`else
    logic w_unused_carry;
    assign w_unused_carry = brl_carry;

    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_c = 1'b0;
`endif

    assign brlmux_1 = r_mode[1];
    assign brlmux_0 = r_mode[0];
    assign srcdp    = r_srcdp;
    assign brld     = r_brld;
    assign wb_valid = r_s2_valid;
    assign wb_data  = r_wb_data;
    assign wb_dreg  = r_wb_dreg;

endmodule
`default_nettype wire
